// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction handshake, register-file and ALU signals of alu_sequencer.
// No latency of its own; it only carries nets.
// master is the sequencer side; slave is the environment (instruction source, register file, ALU).
interface alu_sequencer_if #(
    parameter int size = 32,
    parameter int c    = 4
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [4:0]        rf_raddr1;
    logic [4:0]        rf_raddr2;
    logic [size-1:0]   rf_rdata1;
    logic [size-1:0]   rf_rdata2;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [size-1:0]   rf_wdata;
    logic [size-1:0]   alu_in1;
    logic [size-1:0]   alu_in2;
    logic [c:0]        alu_shamt;
    logic [c-1:0]      alu_control;
    logic [size-1:0]   alu_out;
    logic [2:0]        alu_flag;
    logic              done;
    logic              err;
    logic [2:0]        flag_q;
    logic [15:0]       retired_cnt;

    modport master (
        input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_flag,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_in1, alu_in2, alu_shamt, alu_control, done, err, flag_q, retired_cnt
    );

    modport slave (
        output instr_valid, instr, rf_rdata1, rf_rdata2, alu_out, alu_flag,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_in1, alu_in2, alu_shamt, alu_control, done, err, flag_q, retired_cnt
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through register read, external ALU and register write.
// Latency: done pulses in the 3rd cycle after the accept edge (2nd for illegal opcodes); 4 cycles min per instruction.
// Backpressure: instr_ready is high only in IDLE and low during rst; ALU_SEQ_CNT_EN enables the retired counter.
module alu_sequencer #(
    parameter int size = 32,
    parameter int c    = 4
) (
    input logic           clk,
    input logic           rst,
    alu_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state;
    logic [31:0]       instr_q;
    logic [4:0]        raddr1_q;
    logic [4:0]        raddr2_q;
    logic [4:0]        waddr_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;
    logic [2:0]        flag_r;
    logic [size-1:0]   result_q;
    logic [size-1:0]   alu_in1_q;
    logic [size-1:0]   alu_in2_q;
    logic [c:0]        shamt_q;
    logic [c-1:0]      ctl_q;

    // Fields of the latched instruction
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        shamt_f;
    logic [3:0]        funct;
    logic [15:0]       imm;
    logic              is_r;
    logic              is_addi;
    logic              is_andi;
    logic              legal;
    logic [size-1:0]   op2;

    assign opcode  = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign shamt_f = instr_q[15:11];
    assign funct   = instr_q[3:0];
    assign imm     = instr_q[15:0];
    assign is_r    = (opcode == 6'b000000);
    assign is_addi = (opcode == 6'b000001);
    assign is_andi = (opcode == 6'b000010);
    assign legal   = is_r | is_addi | is_andi;

    // Second ALU operand: rt data for R-type, sign-extended imm for addi, zero-extended imm for andi
    always_comb begin
        op2 = bus.rf_rdata2;
        if (is_addi)
            op2 = size'($signed(imm));
        else if (is_andi)
            op2 = size'(imm);
    end

    // ALU operands follow the register file only during EXEC, then hold what EXEC used
    assign bus.alu_in1     = (state == EXEC) ? bus.rf_rdata1 : alu_in1_q;
    assign bus.alu_in2     = (state == EXEC) ? op2 : alu_in2_q;
    assign bus.alu_shamt   = shamt_q;
    assign bus.alu_control = ctl_q;

    assign bus.instr_ready = (state == IDLE) && !rst;
    assign bus.rf_raddr1   = raddr1_q;
    assign bus.rf_raddr2   = raddr2_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = result_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.flag_q      = flag_r;

    // Sequencer FSM with all its registered outputs; write/done/err are single-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            instr_q   <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flag_r    <= '0;
            result_q  <= '0;
            alu_in1_q <= '0;
            alu_in2_q <= '0;
            shamt_q   <= '0;
            ctl_q     <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q  <= bus.instr;
                        raddr1_q <= bus.instr[25:21];
                        raddr2_q <= bus.instr[20:16];
                        state    <= READ;
                    end
                end
                READ: begin
                    if (legal) begin
                        ctl_q   <= is_r ? c'(funct) : (is_addi ? c'(4'b0000) : c'(4'b0011));
                        shamt_q <= (c+1)'(shamt_f);
                        state   <= EXEC;
                    end else begin
                        // Illegal: no ALU pass, no write, flags untouched
                        waddr_q <= rs;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state   <= WB;
                    end
                end
                EXEC: begin
                    result_q  <= bus.alu_out;
                    alu_in1_q <= bus.rf_rdata1;
                    alu_in2_q <= op2;
                    flag_r    <= flag_r | bus.alu_flag;
                    waddr_q   <= rs;
                    we_q      <= (rs != 5'd0);
                    done_q    <= 1'b1;
                    state     <= WB;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_CNT_EN
    logic [15:0] cnt_q;

    // Count legal instructions as they leave WB; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (state == WB && !err_q)
            cnt_q <= cnt_q + 16'd1;
    end

    assign bus.retired_cnt = cnt_q;
`else
    assign bus.retired_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: register file and ALU models around the DUT plus an instruction-level reference.
// Inputs change on the falling edge; outputs are checked on the falling edge or shortly after it.
// Directed cases first, then randomized instructions with random valid hold and idle gaps.
module tb_alu_sequencer;
    localparam int size = 32;
    localparam int c    = 4;
`ifdef ALU_SEQ_CNT_EN
    localparam bit cnt_en = 1'b1;
`else
    localparam bit cnt_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.size(size), .c(c)) bus ();
    alu_sequencer #(.size(size), .c(c)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [size-1:0] m_regs [32];
    logic [size-1:0] rf_mem [32];
    logic [2:0]      m_flags;
    logic [15:0]     m_cnt;

    // Environment ALU: returns {zero, negative, carry, result}
    function automatic logic [size+2:0] alu_calc(input logic [c-1:0] ctl, input logic [size-1:0] a,
                                                 input logic [size-1:0] b, input logic [c:0] sh);
        logic [size:0]   sum;
        logic [size-1:0] r;
        logic            cy;
        cy = 1'b0;
        case (int'(ctl))
            0: begin sum = {1'b0, a} + {1'b0, b}; r = sum[size-1:0]; cy = sum[size]; end
            1: r = a - b;
            2: r = a | b;
            3: r = a & b;
            4: r = a ^ b;
            5: r = a << sh;
            6: r = a >> sh;
            default: r = b;
        endcase
        return {(r == '0), r[size-1], cy, r};
    endfunction

    assign {bus.alu_flag, bus.alu_out} = alu_calc(bus.alu_control, bus.alu_in1, bus.alu_in2, bus.alu_shamt);

    // Register file: synchronous read, reloaded from the reference contents while in reset
    always @(posedge clk) begin
        if (rst)
            rf_mem <= m_regs;
        else if (bus.rf_we)
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
        bus.rf_rdata1 <= rf_mem[bus.rf_raddr1];
        bus.rf_rdata2 <= rf_mem[bus.rf_raddr2];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One instruction from the IDLE cycle through WB; returns at the falling edge inside WB
    task automatic issue(input logic [31:0] ins, input bit keep);
        logic [5:0]      op;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic            legal;
        logic [size-1:0] a;
        logic [size-1:0] b;
        logic [c-1:0]    ctl;
        logic [size+2:0] rr;
        op    = ins[31:26];
        rs    = ins[25:21];
        rt    = ins[20:16];
        legal = (op <= 6'd2);
        a     = m_regs[rs];
        b     = '0;
        ctl   = '0;
        if (op == 6'd0) begin
            b   = m_regs[rt];
            ctl = c'(ins[3:0]);
        end else if (op == 6'd1) begin
            b   = size'($signed(ins[15:0]));
            ctl = c'(0);
        end else if (op == 6'd2) begin
            b   = size'(ins[15:0]);
            ctl = c'(3);
        end
        rr = alu_calc(ctl, a, b, (c+1)'(ins[15:11]));

        @(negedge clk);
        check("idle_ready", bus.instr_ready, 1);
        check("idle_done", bus.done, 0);
        check("idle_flag_q", bus.flag_q, m_flags);
        check("idle_retired", bus.retired_cnt, cnt_en ? m_cnt : 16'h0);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;

        @(negedge clk);
        bus.instr       = $urandom;
        bus.instr_valid = keep;
        check("read_raddr1", bus.rf_raddr1, rs);
        check("read_raddr2", bus.rf_raddr2, rt);
        check("read_ready", bus.instr_ready, 0);
        check("read_done", bus.done, 0);

        if (legal) begin
            @(negedge clk);
            check("exec_ctl", bus.alu_control, ctl);
            check("exec_in1", bus.alu_in1, a);
            check("exec_in2", bus.alu_in2, b);
            if (op == 6'd0)
                check("exec_shamt", bus.alu_shamt, ins[15:11]);
            check("exec_done", bus.done, 0);
            m_flags = m_flags | rr[size+2:size];
        end

        @(negedge clk);
        check("wb_done", bus.done, 1);
        check("wb_err", bus.err, !legal);
        check("wb_we", bus.rf_we, legal && (rs != 5'd0));
        check("wb_retired", bus.retired_cnt, cnt_en ? m_cnt : 16'h0);
        if (legal) begin
            check("wb_wdata", bus.rf_wdata, rr[size-1:0]);
            if (rs != 5'd0) begin
                check("wb_waddr", bus.rf_waddr, rs);
                m_regs[rs] = rr[size-1:0];
            end
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] ins;
        for (int i = 0; i < 32; i++)
            m_regs[i] = $urandom;
        m_regs[3] = 32'd5;
        m_regs[4] = 32'd7;
        m_regs[2] = 32'd10;
        m_flags   = '0;
        m_cnt     = '0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        rst             = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_we", bus.rf_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_flag_q", bus.flag_q, 0);
        check("rst_retired", bus.retired_cnt, 0);
        check("rst_alu_in1", bus.alu_in1, 0);
        check("rst_alu_ctl", bus.alu_control, 0);
        check("rst_raddr1", bus.rf_raddr1, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        rst = 1'b0;

        // R-type add r3 = 5 + 7
        issue(mk(6'd0, 5'd3, 5'd4, 16'h0000), 1'b0);
        check("add_wdata", bus.rf_wdata, 32'd12);
        check("add_waddr", bus.rf_waddr, 5'd3);

        // addi r2 = 10 + sext(FFFF); alu_in2 holds its EXEC value in WB
        issue(mk(6'd1, 5'd2, 5'd9, 16'hFFFF), 1'b0);
        check("addi_wdata", bus.rf_wdata, 32'd9);
        check("addi_in2_hold", bus.alu_in2, 32'hFFFF_FFFF);

        // Illegal opcode: err with done, no write, flags and count untouched
        issue(mk(6'b000111, 5'd5, 5'd6, 16'h1234), 1'b0);

        // Write to r0 is suppressed but still completes
        issue(mk(6'd0, 5'd0, 5'd3, 16'h0000), 1'b0);

        // Back-to-back issue with instr_valid held high
        issue(mk(6'd2, 5'd7, 5'd1, 16'h00F0), 1'b1);
        issue(mk(6'd0, 5'd8, 5'd3, {5'd2, 7'd0, 4'd5}), 1'b1);
        issue(mk(6'd1, 5'd9, 5'd0, 16'h0003), 1'b1);
        bus.instr_valid = 1'b0;

        // Reset during EXEC discards the instruction
        @(negedge clk);
        bus.instr       = mk(6'd0, 5'd5, 5'd6, 16'h0000);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_we", bus.rf_we, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_ready", bus.instr_ready, 0);
        check("mid_rst_flag_q", bus.flag_q, 0);
        check("mid_rst_alu_in1", bus.alu_in1, 0);
        @(negedge clk);
        rst     = 1'b0;
        m_flags = '0;
        m_cnt   = '0;
        #1;
        check("post_rst_ready", bus.instr_ready, 1);
        check("post_rst_flag_q", bus.flag_q, 0);
        check("post_rst_retired", bus.retired_cnt, 0);
        check("post_rst_wdata", bus.rf_wdata, 0);

        // Randomized instruction mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 4: op = 6'd0;
                1: op = 6'd1;
                2: op = 6'd2;
                default: op = 6'($urandom_range(3, 63));
            endcase
            ins = mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom));
            if (op == 6'd0)
                ins[3:0] = 4'($urandom_range(0, 7));
            issue(ins, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.instr_valid = 1'b0;

`ifdef ALU_SEQ_CNT_EN
        // Counter wrap: 65537 legal instructions from zero leave a count of 1
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_flags = '0;
        m_cnt   = '0;
        for (int i = 0; i < 65537; i++)
            issue(mk(6'd1, 5'd1, 5'd0, 16'h0001), 1'b1);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("cnt_wrap", bus.retired_cnt, 16'd1);
`endif

        @(negedge clk);
        check("final_ready", bus.instr_ready, 1);
        check("final_flag_q", bus.flag_q, m_flags);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
